result_bcd_converter: RTL and testbench
=======================================

// Module: result_bcd_converter
// PURPOSE
//   Sequential binary-to-BCD converter using the double-dabble algorithm.
//   Sits directly downstream of the arithmetic stages, e.g. square_root: start <= done, bin_in <= sq_root.
//   Delivers packed BCD digits to the seven-segment display driver.
//   One conversion at a time; result is held until the next conversion completes.
// PARAMETERS
//   N       16  width of the binary input (instantiate as N=`INPUTWIDTH/2 behind square_root)
//   DIGITS   5  number of BCD digits produced; 10^DIGITS >= 2^N required for overflow-free operation
// PORTS
//   Clock     in   1          system clock, rising edge
//   reset     in   1          synchronous, active-high reset
//   start     in   1          1-cycle request; bin_in sampled on the same edge
//   bin_in    in   N          binary value to convert
//   busy      out  1          high while a conversion is in progress
//   valid     out  1          1-cycle pulse: bcd_out/overflow updated this cycle
//   bcd_out   out  4*DIGITS   packed BCD result; [3:0] = units digit
//   overflow  out  1          value did not fit in DIGITS digits (bcd_out = low digits only)
//   neg       out  1          result sign (port exists only with BCD_SIGN_EN)
// BEHAVIOUR
//   Reset values (reset wins over start in the same cycle):
//   - busy=0, valid=0, bcd_out=0, overflow=0, neg=0
//   - FSM=IDLE; internal shift register, accumulator and counter cleared
//   - Reset mid-conversion aborts it; no valid is produced.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:
//   - on start: latch bin_in into shift reg, clear BCD accumulator and ovf sticky, cnt=0, busy=1 -> SHIFT
//   - without start: outputs hold
//   SHIFT (one bit per cycle):
//   - first: every accumulator digit >= 5 gets +3 (4-bit add, no inter-digit carry)
//   - then: {carry, acc, sreg} shifted left by 1
//   - carry out of the top digit sets sticky ovf
//   - cnt++; after N shift cycles -> DONE
//   DONE:
//   - bcd_out <= acc, overflow <= ovf, valid=1 for exactly this cycle, busy=0 -> IDLE
//   Timing:
//   - Latency: start on edge t -> valid high in cycle t+N+1 (N=16: 17 cycles).
//   - New start accepted the cycle after valid; start while busy=1 (SHIFT/DONE) is ignored, not queued.
//   Outputs:
//   - bcd_out/overflow/neg change only in the valid cycle; stable otherwise.
//   - Every digit of bcd_out is always 0..9; leading zeros are not blanked (display driver's job).
//   - bin_in is not required to stay stable after the start edge.
// CONFIGURATION
//   BCD_SIGN_EN defined:
//   - bin_in is two's complement.
//   - On start: neg latched = bin_in[N-1]; shift reg = |bin_in| as an N-bit unsigned value
//     (-2^(N-1) -> 2^(N-1), no overflow).
//   - neg is updated with bcd_out in the valid cycle.
//   BCD_SIGN_EN undefined:
//   - bin_in unsigned; neg port and its logic absent.
//   - Conversion path and timing otherwise identical.
// TESTING
//   1. N=16,D=5: start with 0 -> valid at t+17; bcd_out=20'h00000, overflow=0.
//   2. start with 65535 -> bcd_out=20'h65535, overflow=0; then 255 -> 20'h00255.
//   3. start with 1234; start=1 again at t+5 with 9999 -> 2nd ignored;
//      single valid with 20'h01234; busy low that cycle.
//   4. N=16,D=3: start with 1234 -> overflow=1, bcd_out=12'h234.
//   5. start with 4321; reset=1 at t+8 -> no valid, bcd_out=0, busy=0.
//      Next start with 7 -> 20'h00007 at +17.
//   6. BCD_SIGN_EN, N=16: -1 -> neg=1, bcd_out=20'h00001; -32768 -> neg=1, 20'h32768;
//      back-to-back 5 -> neg=0.

Source files
------------

// File: rtl/result_bcd_converter.sv
// -----------------------------------------------------------------------------
// result_bcd_converter
//
// Sequential binary-to-BCD converter using the double-dabble (shift-and-add-3)
// algorithm. It sits directly behind the arithmetic stages (for example
// square_root: start <= done, bin_in <= sq_root) and feeds packed BCD digits
// to the seven-segment display driver. One conversion runs at a time. The
// result is held until the next conversion completes.
//
// Optional feature macro: BCD_SIGN_EN
//   defined   : bin_in is two's complement. The magnitude is converted and the
//               sign is reported on the extra 'neg' output.
//   undefined : bin_in is unsigned and the 'neg' port does not exist.
//
// Parameters
//   N        width of the binary input
//   DIGITS   number of BCD digits produced (10^DIGITS >= 2^N for no overflow)
//
// Ports
//   Clock     in   1          system clock, rising edge
//   reset     in   1          synchronous, active-high reset (wins over start)
//   start     in   1          1-cycle request; bin_in is sampled on the same edge
//   bin_in    in   N          binary value to convert
//   busy      out  1          high while a conversion is in progress
//   valid     out  1          1-cycle pulse: bcd_out/overflow updated this cycle
//   bcd_out   out  4*DIGITS   packed BCD result, [3:0] = units digit
//   overflow  out  1          value did not fit in DIGITS digits (low digits kept)
//   neg       out  1          result sign (BCD_SIGN_EN builds only)
//
// Timing: start on edge t gives valid high after edge t+N+1. A start that
// arrives while busy is high is dropped, not queued.
// -----------------------------------------------------------------------------
module result_bcd_converter #(
    parameter int N      = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N-1:0]          bin_in,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BCD_SIGN_EN
    output logic                  overflow,
    output logic                  neg
`else
    output logic                  overflow
`endif
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Add 3 to every digit that is 5 or more. Each digit is a separate 4-bit
    // add with no carry into the next digit. An adjusted digit is at most 12,
    // so it still fits in 4 bits.
    function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] res;
        res = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return res;
    endfunction

`ifdef BCD_SIGN_EN
    // Take the absolute value as an N-bit unsigned number. The most negative
    // input maps to 2^(N-1), which still fits in N unsigned bits.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
        logic [N-1:0] res;
        if (v[N-1]) begin
            res = ~v + {{(N-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction
`endif

    // FSM state
    state_t             state_q, state_d;

    // FSM-decoded datapath controls
    logic               load_s;
    logic               shift_s;
    logic               finish_s;

    // Conversion datapath
    logic [N-1:0]       sreg_q,     sreg_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic [ACC_W-1:0]   acc_adj_s;
    logic               ovf_q,      ovf_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    // Registered outputs
    logic               busy_q,     busy_d;
    logic               valid_q,    valid_d;
    logic [ACC_W-1:0]   bcd_q,      bcd_d;
    logic               overflow_q, overflow_d;
`ifdef BCD_SIGN_EN
    logic               neg_lat_q,  neg_lat_d;
    logic               neg_q,      neg_d;
`endif

    // FSM state register
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. The last shift is the one taken while cnt is N-1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: datapath control strobes. A start seen outside IDLE
    // is simply not decoded, so it is dropped rather than queued.
    always_comb begin
        load_s   = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_s = start;
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
            end
            ST_DONE: begin
                finish_s = 1'b1;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    assign acc_adj_s = dabble_adjust(acc_q);

    // Datapath next-state logic: load, one shift per cycle, and publish
    always_comb begin
        sreg_d     = sreg_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
`ifdef BCD_SIGN_EN
        neg_lat_d  = neg_lat_q;
        neg_d      = neg_q;
`endif
        if (load_s) begin
`ifdef BCD_SIGN_EN
            sreg_d    = magnitude(bin_in);
            neg_lat_d = bin_in[N-1];
`else
            sreg_d    = bin_in;
`endif
            acc_d     = '0;
            ovf_d     = 1'b0;
            cnt_d     = '0;
            busy_d    = 1'b1;
        end else if (shift_s) begin
            // Shift {carry, acc, sreg} left by one. The bit pushed out of the
            // top digit would be the next decimal digit, so it is recorded as
            // a sticky overflow.
            {acc_d, sreg_d} = {acc_adj_s[ACC_W-2:0], sreg_q, 1'b0};
            ovf_d           = ovf_q | acc_adj_s[ACC_W-1];
            cnt_d           = cnt_q + CNT_W'(1);
        end else if (finish_s) begin
            bcd_d      = acc_q;
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            busy_d     = 1'b0;
`ifdef BCD_SIGN_EN
            neg_d      = neg_lat_q;
`endif
        end else begin
            valid_d = 1'b0;
        end
    end

    // Datapath and output registers. Reset also aborts a conversion in flight.
    always_ff @(posedge Clock) begin
        if (reset) begin
            sreg_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
`ifdef BCD_SIGN_EN
            neg_lat_q  <= 1'b0;
            neg_q      <= 1'b0;
`endif
        end else begin
            sreg_q     <= sreg_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
`ifdef BCD_SIGN_EN
            neg_lat_q  <= neg_lat_d;
            neg_q      <= neg_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;
`ifdef BCD_SIGN_EN
    assign neg      = neg_q;
`endif

endmodule

// File: tb/tb_result_bcd_converter.sv
module tb_result_bcd_converter;

    logic        Clock;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;

    logic        busy,  valid,  overflow;
    logic [19:0] bcd_out;
    logic        busy3, valid3, overflow3;
    logic [11:0] bcd3;
`ifdef BCD_SIGN_EN
    logic        neg, neg3;
`endif

    int total = 0;
    int bad   = 0;

    int          first_k, nvalid;
    logic        busy_v, v3;
    logic [19:0] mid_bcd;

    result_bcd_converter #(.N(16), .DIGITS(5)) dut (
        .Clock(Clock), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .valid(valid), .bcd_out(bcd_out),
`ifdef BCD_SIGN_EN
        .overflow(overflow), .neg(neg)
`else
        .overflow(overflow)
`endif
    );

    result_bcd_converter #(.N(16), .DIGITS(3)) dut3 (
        .Clock(Clock), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy3), .valid(valid3), .bcd_out(bcd3),
`ifdef BCD_SIGN_EN
        .overflow(overflow3), .neg(neg3)
`else
        .overflow(overflow3)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one conversion, then tick up to 40 cycles. Optionally inject a
    // second start at tick inj_k or a reset at tick rst_k. Without 'full' the
    // loop stops in the first valid cycle so the caller can start back-to-back.
    task automatic run(input logic [15:0] val, input int inj_k, input logic [15:0] inj_val,
                       input int rst_k, input bit full,
                       output int fk, output int nv, output logic bv, output logic v3o,
                       output logic [19:0] mid);
        start  = 1'b1;
        bin_in = val;
        tick();
        start  = 1'b0;
        bin_in = 16'hA5A5;
        fk  = -1;
        nv  = 0;
        bv  = 1'bx;
        v3o = 1'bx;
        mid = 20'h0;
        for (int k = 1; k <= 40; k++) begin
            start = (k == inj_k);
            if (k == inj_k) bin_in = inj_val;
            reset = (k == rst_k);
            tick();
            start  = 1'b0;
            reset  = 1'b0;
            bin_in = 16'h5A5A;
            if (k == 8) mid = bcd_out;
            if (valid === 1'b1) begin
                nv++;
                if (fk < 0) begin
                    fk  = k;
                    bv  = busy;
                    v3o = valid3;
                end
                if (!full) break;
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 16'h0;
        tick();
        tick();
        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_valid", {31'd0, valid},    32'd0);
        check("rst_bcd",   {12'd0, bcd_out},  32'd0);
        check("rst_ovf",   {31'd0, overflow}, 32'd0);
        check("rst_busy3", {31'd0, busy3},    32'd0);
`ifdef BCD_SIGN_EN
        check("rst_neg",   {31'd0, neg},      32'd0);
`endif
        // Reset wins over start in the same cycle, and the start is not remembered
        start = 1'b1;
        bin_in = 16'd99;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_vs_start_busy", {31'd0, busy}, 32'd0);
        tick();
        check("rst_vs_start_busy2", {31'd0, busy}, 32'd0);

        // Zero converts to all-zero digits, valid 17 cycles after start
        run(16'd0, 0, 16'd0, 0, 1'b0, first_k, nvalid, busy_v, v3, mid_bcd);
        check("zero_latency", first_k,            32'd17);
        check("zero_bcd",     {12'd0, bcd_out},   32'h00000);
        check("zero_ovf",     {31'd0, overflow},  32'd0);
        check("zero_v3",      {31'd0, v3},        32'd1);
        tick();
        check("valid_pulse",  {31'd0, valid},     32'd0);
        check("hold_bcd",     {12'd0, bcd_out},   32'h00000);

`ifndef BCD_SIGN_EN
        // Full-scale value, then a back-to-back start in the valid cycle
        run(16'd65535, 0, 16'd0, 0, 1'b0, first_k, nvalid, busy_v, v3, mid_bcd);
        check("max_latency",  first_k,            32'd17);
        check("max_bcd",      {12'd0, bcd_out},   32'h65535);
        check("max_ovf",      {31'd0, overflow},  32'd0);
        check("max_bcd3",     {20'd0, bcd3},      32'h535);
        check("max_ovf3",     {31'd0, overflow3}, 32'd1);
        run(16'd255, 0, 16'd0, 0, 1'b0, first_k, nvalid, busy_v, v3, mid_bcd);
        check("b2b_latency",  first_k,            32'd17);
        check("b2b_mid_hold", {12'd0, mid_bcd},   32'h65535);
        check("b2b_bcd",      {12'd0, bcd_out},   32'h00255);
`endif

        // Second start while busy is ignored; one valid only, busy low with it
        run(16'd1234, 5, 16'd9999, 0, 1'b1, first_k, nvalid, busy_v, v3, mid_bcd);
        check("ign_latency",  first_k,            32'd17);
        check("ign_nvalid",   nvalid,             32'd1);
        check("ign_busy",     {31'd0, busy_v},    32'd0);
        check("ign_bcd",      {12'd0, bcd_out},   32'h01234);
        check("ign_ovf",      {31'd0, overflow},  32'd0);
        // Three-digit instance keeps only the low digits and flags overflow
        check("d3_bcd",       {20'd0, bcd3},      32'h234);
        check("d3_ovf",       {31'd0, overflow3}, 32'd1);

        // Reset mid-conversion aborts with no valid and clears the result
        run(16'd4321, 0, 16'd0, 8, 1'b1, first_k, nvalid, busy_v, v3, mid_bcd);
        check("abort_nvalid", nvalid,             32'd0);
        check("abort_busy",   {31'd0, busy},      32'd0);
        check("abort_bcd",    {12'd0, bcd_out},   32'h00000);
        check("abort_bcd3",   {20'd0, bcd3},      32'h000);
        run(16'd7, 0, 16'd0, 0, 1'b0, first_k, nvalid, busy_v, v3, mid_bcd);
        check("after_abort_latency", first_k,            32'd17);
        check("after_abort_bcd",     {12'd0, bcd_out},   32'h00007);
        check("after_abort_ovf3",    {31'd0, overflow3}, 32'd0);
        check("after_abort_bcd3",    {20'd0, bcd3},      32'h007);

`ifdef BCD_SIGN_EN
        // Signed inputs: the magnitude is converted and the sign goes to neg
        run(16'hFFFF, 0, 16'd0, 0, 1'b0, first_k, nvalid, busy_v, v3, mid_bcd);
        check("m1_latency", first_k,          32'd17);
        check("m1_neg",     {31'd0, neg},     32'd1);
        check("m1_bcd",     {12'd0, bcd_out}, 32'h00001);
        run(16'h8000, 0, 16'd0, 0, 1'b0, first_k, nvalid, busy_v, v3, mid_bcd);
        check("min_neg",    {31'd0, neg},     32'd1);
        check("min_bcd",    {12'd0, bcd_out}, 32'h32768);
        check("min_ovf",    {31'd0, overflow},32'd0);
        check("min_bcd3",   {20'd0, bcd3},    32'h768);
        run(16'd5, 0, 16'd0, 0, 1'b0, first_k, nvalid, busy_v, v3, mid_bcd);
        check("p5_latency", first_k,          32'd17);
        check("p5_neg",     {31'd0, neg},     32'd0);
        check("p5_bcd",     {12'd0, bcd_out}, 32'h00005);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
